// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed display scanner: the scan FSM
// state encoding and the 7-bit hex glyphs (a at bit 6 .. g at bit 0).
package display_scan_ctrl_pkg;

   typedef logic [0:0] scan_state_t;

   localparam scan_state_t ST_DRIVE = 1'b0;
   localparam scan_state_t ST_BLANK = 1'b1;

   localparam logic [6:0] GLYPH_0 = 7'h7E;
   localparam logic [6:0] GLYPH_1 = 7'h30;
   localparam logic [6:0] GLYPH_2 = 7'h6D;
   localparam logic [6:0] GLYPH_3 = 7'h79;
   localparam logic [6:0] GLYPH_4 = 7'h33;
   localparam logic [6:0] GLYPH_5 = 7'h5B;
   localparam logic [6:0] GLYPH_6 = 7'h5F;
   localparam logic [6:0] GLYPH_7 = 7'h70;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h7B;
   localparam logic [6:0] GLYPH_A = 7'h77;
   localparam logic [6:0] GLYPH_B = 7'h1F;
   localparam logic [6:0] GLYPH_C = 7'h4E;
   localparam logic [6:0] GLYPH_D = 7'h3D;
   localparam logic [6:0] GLYPH_E = 7'h4F;
   localparam logic [6:0] GLYPH_F = 7'h47;

endpackage

// File: rtl/display_scan_ctrl_seven_segment.sv
// Hex nibble to seven-segment decoder; glyph in bits 6:0, bit 7 left clear
// so the caller can merge its own decimal point.
module seven_segment
   import display_scan_ctrl_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] segments
);

   // Look up the active-high glyph for the nibble.
   always_comb begin
      segments = 8'h00;
      case (nibble)
         4'h0:    segments = {1'b0, GLYPH_0};
         4'h1:    segments = {1'b0, GLYPH_1};
         4'h2:    segments = {1'b0, GLYPH_2};
         4'h3:    segments = {1'b0, GLYPH_3};
         4'h4:    segments = {1'b0, GLYPH_4};
         4'h5:    segments = {1'b0, GLYPH_5};
         4'h6:    segments = {1'b0, GLYPH_6};
         4'h7:    segments = {1'b0, GLYPH_7};
         4'h8:    segments = {1'b0, GLYPH_8};
         4'h9:    segments = {1'b0, GLYPH_9};
         4'hA:    segments = {1'b0, GLYPH_A};
         4'hB:    segments = {1'b0, GLYPH_B};
         4'hC:    segments = {1'b0, GLYPH_C};
         4'hD:    segments = {1'b0, GLYPH_D};
         4'hE:    segments = {1'b0, GLYPH_E};
         4'hF:    segments = {1'b0, GLYPH_F};
         default: segments = 8'h00;
      endcase
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed seven-segment scanner: time-slices N_DIGITS digits with an
// anti-ghost blanking tail per slot, and double-buffers new display data so
// it only becomes visible at a frame boundary.
module display_scan_ctrl
   import display_scan_ctrl_pkg::*;
#(
   parameter int N_DIGITS   = 4,
   parameter int DIGIT_CYC  = 100000,
   parameter int BLANK_CYC  = 16,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*N_DIGITS-1:0] value,
   input  logic [N_DIGITS-1:0]   dp_mask,
   input  logic                  blank_lz,
   input  logic                  load,
   output logic                  load_ack,
   output logic [N_DIGITS-1:0]   an,
   output logic [7:0]            seg,
   output logic                  frame_done
);

   localparam int CNT_W = $clog2(DIGIT_CYC);
   localparam int IDX_W = $clog2(N_DIGITS);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYC - 1);
   localparam logic [CNT_W-1:0] DRIVE_END = CNT_W'(DIGIT_CYC - BLANK_CYC);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
   localparam logic             POL       = (ACTIVE_LOW != 0);
   localparam logic [N_DIGITS-1:0] AN_POL = {N_DIGITS{POL}};
   localparam logic [7:0]          SEG_POL = {8{POL}};

   logic [CNT_W-1:0]      cnt_r;
   logic [CNT_W-1:0]      cnt_next_s;
   logic [IDX_W-1:0]      idx_r;
   scan_state_t           state_r;
   scan_state_t           state_next_s;
   logic                  cnt_wrap_s;
   logic                  frame_end_s;

   logic                  pend_r;
   logic [4*N_DIGITS-1:0] pend_value_r;
   logic [N_DIGITS-1:0]   pend_dp_r;
   logic                  pend_blz_r;
   logic [4*N_DIGITS-1:0] disp_value_r;
   logic [N_DIGITS-1:0]   disp_dp_r;
   logic                  disp_blz_r;

   logic [3:0]            nibble_s;
   logic                  dp_bit_s;
   logic                  lz_hit_s;
   logic                  zero_run_s;
   logic [7:0]            glyph_s;
   logic [N_DIGITS-1:0]   an_hi_s;
   logic [7:0]            seg_hi_s;

   logic [N_DIGITS-1:0]   an_r;
   logic [7:0]            seg_r;
   logic                  load_ack_r;
   logic                  frame_done_r;

   // Slot counter next value, wrap detection and next FSM state.
   always_comb begin
      cnt_wrap_s  = (cnt_r == CNT_LAST);
      frame_end_s = cnt_wrap_s && (idx_r == IDX_LAST);
      if (cnt_wrap_s) begin
         cnt_next_s = {CNT_W{1'b0}};
      end else begin
         cnt_next_s = cnt_r + CNT_W'(1);
      end
      if (cnt_next_s < DRIVE_END) begin
         state_next_s = ST_DRIVE;
      end else begin
         state_next_s = ST_BLANK;
      end
   end

   // Scan timing: slot counter, digit index and DRIVE/BLANK state.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r   <= {CNT_W{1'b0}};
         idx_r   <= {IDX_W{1'b0}};
         state_r <= ST_DRIVE;
      end else begin
         cnt_r   <= cnt_next_s;
         state_r <= state_next_s;
         if (cnt_wrap_s) begin
            idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
         end
      end
   end

   // Pending capture on load; commit to the display buffer at frame end.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_r        <= 1'b0;
         pend_value_r  <= {(4*N_DIGITS){1'b0}};
         pend_dp_r     <= {N_DIGITS{1'b0}};
         pend_blz_r    <= 1'b0;
         disp_value_r  <= {(4*N_DIGITS){1'b0}};
         disp_dp_r     <= {N_DIGITS{1'b0}};
         disp_blz_r    <= 1'b0;
         load_ack_r    <= 1'b0;
         frame_done_r  <= 1'b0;
      end else begin
         if (frame_end_s && pend_r) begin
            disp_value_r <= pend_value_r;
            disp_dp_r    <= pend_dp_r;
            disp_blz_r   <= pend_blz_r;
         end
         // A load in the boundary cycle lands in pending for the next frame.
         if (load) begin
            pend_r       <= 1'b1;
            pend_value_r <= value;
            pend_dp_r    <= dp_mask;
            pend_blz_r   <= blank_lz;
         end else if (frame_end_s) begin
            pend_r <= 1'b0;
         end
         load_ack_r   <= frame_end_s && pend_r;
         frame_done_r <= frame_end_s;
      end
   end

   // Current-digit mux, leading-zero detection and one-hot anode.
   always_comb begin
      nibble_s   = 4'h0;
      dp_bit_s   = 1'b0;
      lz_hit_s   = 1'b0;
      zero_run_s = 1'b1;
      an_hi_s    = {N_DIGITS{1'b0}};
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         zero_run_s = zero_run_s && (disp_value_r[i*4 +: 4] == 4'h0);
         if (idx_r == IDX_W'(i)) begin
            nibble_s   = disp_value_r[i*4 +: 4];
            dp_bit_s   = disp_dp_r[i];
            lz_hit_s   = zero_run_s && (i != 0);
            an_hi_s[i] = (state_r == ST_DRIVE);
         end else begin
            an_hi_s[i] = 1'b0;
         end
      end
   end

   seven_segment u_seven_segment (
      .nibble   (nibble_s),
      .segments (glyph_s)
   );

   // Active-high segment pattern: glyph (unless leading-zero blanked) plus dp.
   always_comb begin
      if (state_r == ST_DRIVE) begin
         seg_hi_s = ((disp_blz_r && lz_hit_s) ? 8'h00 : glyph_s) | {dp_bit_s, 7'h00};
      end else begin
         seg_hi_s = 8'h00;
      end
   end

   // Registered, polarity-adjusted display outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_r  <= AN_POL;
         seg_r <= SEG_POL;
      end else begin
         an_r  <= an_hi_s ^ AN_POL;
         seg_r <= seg_hi_s ^ SEG_POL;
      end
   end

   assign an         = an_r;
   assign seg        = seg_r;
   assign load_ack   = load_ack_r;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: two instances (active-high and
// active-low) share stimulus; a vector table covers glyphs, dp and
// leading-zero blanking, followed by load/reset corner sequences.
module tb_display_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] value = 16'h0000;
   logic [3:0]  dp_mask = 4'h0;
   logic        blank_lz = 1'b0;
   logic        load = 1'b0;
   logic [3:0]  an0, an1;
   logic [7:0]  seg0, seg1;
   logic        ack0, ack1, fd0, fd1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] value;
      logic [3:0]  dp;
      logic        blz;
      logic [31:0] segs;   // {digit3, digit2, digit1, digit0} expected seg
   } vec_t;

   vec_t vecs [8];

   display_scan_ctrl #(.N_DIGITS(4), .DIGIT_CYC(8), .BLANK_CYC(2), .ACTIVE_LOW(0)) dut0 (
      .clk(clk), .rst(rst), .value(value), .dp_mask(dp_mask), .blank_lz(blank_lz),
      .load(load), .load_ack(ack0), .an(an0), .seg(seg0), .frame_done(fd0)
   );

   display_scan_ctrl #(.N_DIGITS(4), .DIGIT_CYC(8), .BLANK_CYC(2), .ACTIVE_LOW(1)) dut1 (
      .clk(clk), .rst(rst), .value(value), .dp_mask(dp_mask), .blank_lz(blank_lz),
      .load(load), .load_ack(ack1), .an(an1), .seg(seg1), .frame_done(fd1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic [3:0] ean, input logic [7:0] eseg,
                          input logic efd, input logic eack);
      chk({nm, "_hi"}, {18'd0, an0, seg0, fd0, ack0}, {18'd0, ean, eseg, efd, eack});
      chk({nm, "_lo"}, {18'd0, an1, seg1, fd1, ack1}, {18'd0, ~ean, ~eseg, efd, eack});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fd(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (fd0 !== 1'b1 && n < 100);
      chk("frame_done_seen", {31'd0, fd0}, 32'd1);
   endtask

   initial begin
      int n;
      int acks;
      int first;
      logic [3:0] ean;
      logic [7:0] eseg;

      vecs[0] = '{16'h12AF, 4'b0000, 1'b0, 32'h306D7747};
      vecs[1] = '{16'h0005, 4'b0000, 1'b1, 32'h0000005B};
      vecs[2] = '{16'h0005, 4'b0000, 1'b0, 32'h7E7E7E5B};
      vecs[3] = '{16'h0000, 4'b0001, 1'b1, 32'h000000FE};
      vecs[4] = '{16'h0300, 4'b1000, 1'b1, 32'h80797E7E};
      vecs[5] = '{16'h89BC, 4'b0100, 1'b1, 32'h7FFB1F4E};
      vecs[6] = '{16'h7D64, 4'b1010, 1'b0, 32'hF03DDF33};
      vecs[7] = '{16'hE000, 4'b0000, 1'b1, 32'h4F7E7E7E};

      // Reset state
      step();
      step();
      chk_out("reset", 4'b0000, 8'h00, 1'b0, 1'b0);
      rst = 1'b0;

      // Table: load, commit at frame end, then one full frame of scan
      for (int v = 0; v < 8; v++) begin
         value    = vecs[v].value;
         dp_mask  = vecs[v].dp;
         blank_lz = vecs[v].blz;
         load     = 1'b1;
         step();
         load = 1'b0;
         wait_fd(n);
         chk_out($sformatf("commit_v%0d", v), 4'b0000, 8'h00, 1'b1, 1'b1);
         for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 8; c++) begin
               step();
               ean  = (c < 6) ? (4'b0001 << d) : 4'b0000;
               eseg = (c < 6) ? vecs[v].segs[8*d +: 8] : 8'h00;
               chk_out($sformatf("scan_v%0d_d%0d_c%0d", v, d, c), ean, eseg,
                       (d == 3 && c == 7), 1'b0);
            end
         end
      end

      // Two loads within one frame: single ack, last data wins
      dp_mask  = 4'b0000;
      blank_lz = 1'b0;
      value = 16'h1111;
      load  = 1'b1;
      step();
      load = 1'b0;
      step();
      value = 16'h2222;
      load  = 1'b1;
      step();
      load = 1'b0;
      acks = 0;
      wait_fd(n);
      acks += int'(ack0);
      step();
      chk_out("overwrite_d0", 4'b0001, 8'h6D, 1'b0, 1'b0);
      for (int i = 0; i < 31; i++) begin
         step();
         acks += int'(ack0);
      end
      chk("overwrite_ack_count", acks, 32'd1);

      // Load in the frame_done cycle: commits one frame later
      chk("boundary_fd_now", {31'd0, fd0}, 32'd1);
      value = 16'h3333;
      load  = 1'b1;
      step();
      load = 1'b0;
      chk_out("boundary_c0", 4'b0001, 8'h6D, 1'b0, 1'b0);
      step();
      chk_out("boundary_c1", 4'b0001, 8'h6D, 1'b0, 1'b0);
      wait_fd(n);
      chk("boundary_frame_len", n, 32'd30);
      chk("boundary_ack", {31'd0, ack0}, 32'd1);
      step();
      chk_out("boundary_new_d0", 4'b0001, 8'h79, 1'b0, 1'b0);

      // Reset mid-slot with a load pending
      step();
      step();
      value = 16'h4444;
      load  = 1'b1;
      step();
      load = 1'b0;
      step();
      rst = 1'b1;
      step();
      chk_out("rst_mid", 4'b0000, 8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      chk_out("post_rst_d0", 4'b0001, 8'h7E, 1'b0, 1'b0);
      acks  = 0;
      first = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         acks += int'(ack0);
         if (fd0 === 1'b1 && first == 0) first = i;
      end
      chk("post_rst_no_ack", acks, 32'd0);
      chk("post_rst_first_fd", first, 32'd31);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
